// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts rising edges of iSIG over a fixed gate window in a
// DIGITS-wide BCD counter, then latches the digits (or all-F on overflow) for
// the 7-segment decoders, clears, and starts the next window.
module freq_gate_counter #(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iSIG,
    input  logic                  iEN,
    output logic [4*DIGITS-1:0]   oLatchBCD,
    output logic                  oVALID,
    output logic                  oOVF,
    output logic                  oGATE
);

    localparam int unsigned BCD_W = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GATE  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(GATE_CYCLES - 1);

    // Input conditioning
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync_d;
    logic               w_edge;

    // Measurement state
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_timer;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;

    // Registered outputs
    logic [BCD_W-1:0]   r_latch;
    logic               r_valid;
    logic               r_ovf_out;
    logic               r_gate;

    // Next-state values
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_timer_nxt;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic               w_ovf_nxt;
    logic [BCD_W-1:0]   w_latch_nxt;
    logic               w_valid_nxt;
    logic               w_ovf_out_nxt;
    logic               w_gate_nxt;

    // BCD increment
    logic [BCD_W-1:0]   w_bcd_inc;
    logic               w_inc_carry;

    assign w_edge    = r_sync2 & ~r_sync_d;
    assign oLatchBCD = r_latch;
    assign oVALID    = r_valid;
    assign oOVF      = r_ovf_out;
    assign oGATE     = r_gate;

    // Two-flop synchronizer for iSIG plus a delay stage for rising-edge detection
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= iSIG;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // Ripple-carry BCD increment; carry out of the top digit flags overflow
    always_comb begin
        w_bcd_inc   = r_bcd;
        w_inc_carry = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (w_inc_carry) begin
                if (r_bcd[4*k +: 4] == 4'd9) begin
                    w_bcd_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_bcd_inc[4*k +: 4] = r_bcd[4*k +: 4] + 4'd1;
                    w_inc_carry         = 1'b0;
                end
            end
        end
    end

    // Next-state, counter and output-register logic
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bcd_nxt     = r_bcd;
        w_ovf_nxt     = r_ovf;
        w_latch_nxt   = r_latch;
        w_valid_nxt   = 1'b0;
        w_ovf_out_nxt = r_ovf_out;

        case (r_state)
            S_IDLE: begin
                if (iEN) begin
                    w_state_nxt = S_GATE;
                    w_timer_nxt = '0;
                end
            end
            S_GATE: begin
                if (!iEN) begin
                    // Abandoned window: discard the partial count, keep last latch
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                    w_bcd_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end else begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                    if (w_edge && !r_ovf) begin
                        // On carry-out the counter holds at all-9s
                        if (w_inc_carry) begin
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_bcd_nxt = w_bcd_inc;
                        end
                    end
                    if (r_timer == TIMER_LAST) begin
                        w_state_nxt = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                w_latch_nxt   = r_ovf ? {BCD_W{1'b1}} : r_bcd;
                w_ovf_out_nxt = r_ovf;
                w_valid_nxt   = 1'b1;
                w_state_nxt   = S_CLEAR;
            end
            S_CLEAR: begin
                w_bcd_nxt   = '0;
                w_timer_nxt = '0;
                w_ovf_nxt   = 1'b0;
                w_state_nxt = iEN ? S_GATE : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_gate_nxt = (w_state_nxt == S_GATE);
    end

    // State, counter and output registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_latch   <= '0;
            r_valid   <= 1'b0;
            r_ovf_out <= 1'b0;
            r_gate    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bcd     <= w_bcd_nxt;
            r_ovf     <= w_ovf_nxt;
            r_latch   <= w_latch_nxt;
            r_valid   <= w_valid_nxt;
            r_ovf_out <= w_ovf_out_nxt;
            r_gate    <= w_gate_nxt;
        end
    end

endmodule
